monitor_event_arbiter: RTL and testbench
========================================

# monitor_event_arbiter

Round-robin arbiter that shares the single Active IoT Devices Monitor counter between several device gateways. Each gateway posts join/leave events with a request/acknowledge handshake. The block serialises them into at most one registered `change`/`on_off` pulse per cycle into the monitor. It keeps a shadow of the monitor count so that it can refuse events that would wrap the counter past full or empty.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesting gateways (2..8).
- `CNT_W`, 8: monitor counter width; the shadow count saturates at 2^CNT_W-1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  N_PORTS  per-port event request, level, held until acked.
- `dir`  in  N_PORTS  per-port event direction: 1 = device joined (+1), 0 = left (-1). Must be stable while `req` is high.
- `freeze`  in  1  when high, no new grants are made; pending requests wait.
- `ack`  out  N_PORTS  one-hot, one-cycle acknowledge to the granted port.
- `nack`  out  1  qualifies `ack`: 1 = event rejected (saturation), no pulse issued.
- `change`  out  1  to monitor: one-cycle count-enable.
- `on_off`  out  1  to monitor: direction for `change` (1 = up).
- `shadow_count`  out  CNT_W  expected monitor count after all issued pulses.
- `busy`  out  1  high while any unmasked `req` bit is pending.

## Operation
- Reset (`rst`=0 at a clock edge) sets `ack`=0, `nack`=0, `change`=0, `on_off`=0, `shadow_count`=0, `busy`=0 and the round-robin pointer to 0.
- A reset asserted mid-handshake discards any grant in flight. Requesters re-present after reset.
- Eligible set = `req` AND NOT `ack`. The port acked in the current cycle is masked, so a requester still holding `req` during its ack cycle is not granted twice.
- Each cycle with `freeze`=0 and a non-empty eligible set:
  - Grant the first eligible port, searching from the pointer upward with wrap-around.
  - Set the pointer to (granted index + 1) mod N_PORTS. The pointer advances on rejected grants too.
- Grant evaluation for the granted port g:
  - If `dir[g]`=1 and `shadow_count`=2^CNT_W-1, or `dir[g]`=0 and `shadow_count`=0: register `ack[g]`=1 and `nack`=1. Keep `change`=0 and leave the shadow unchanged.
  - Otherwise: register `ack[g]`=1, `nack`=0, `change`=1, `on_off`=`dir[g]`, and update `shadow_count` by ±1.
- With no grant, `ack`, `nack` and `change` return to 0. `on_off` holds its last value.
- `freeze`=1 blocks new grants only. An ack/pulse already registered still appears.
- `busy` is the registered OR of the eligible set.
- Simultaneous requests are granted one per cycle in rotation order. N requests complete in N consecutive cycles.
- The shadow always equals the monitor count, provided the monitor is reset together with this block and driven only from it.

## Timing
- If `req[g]` is high in cycle T and g wins, `ack[g]`/`nack`/`change`/`on_off` are high in T+1 for exactly one cycle.
- `shadow_count` takes its new value in T+1. The monitor `counter_out` reflects the event in T+2.
- A requester drops `req` (or presents a new event with new `dir`) in the cycle after it sees `ack`. The earliest re-grant of the same port is T+2.
- Worst-case wait for any port with all ports requesting and `freeze`=0 is N_PORTS cycles.
- Throughput is one event per cycle. Back-to-back pulses to the monitor are legal.

## Test plan
- Reset: drive `rst`=0 for 2 cycles with all `req`=1. All outputs must be 0 and no `ack` may appear while in reset. The first grant after release goes to port 0.
- Single port: `req[2]`=1, `dir[2]`=1 for one handshake.
  - Expect `ack`=4'b0100, `change`=1, `on_off`=1 one cycle later.
  - `shadow_count`=1, and monitor `counter_out`=1 one further cycle later.
- Rotation: starting from the reset pointer, `req`=4'b1111 held high with immediate re-request.
  - Ack order 0,1,2,3,0,... with one ack per cycle and no port acked in consecutive cycles.
  - All `dir`=1 gives `shadow_count` 1,2,3,4,...
- Saturation: preload 255 increments, then one more `dir`=1 request. Expect `ack`, `nack`=1, `change`=0, `shadow_count` stays 255. A following `dir`=0 gives 254 with `change`=1, `on_off`=0.
- Underflow and freeze:
  - From reset, a `dir`=0 request gets `nack`=1 and `shadow_count` stays 0.
  - With `freeze`=1 and `req`=4'b0011, no `ack` for 5 cycles while `busy`=1. After `freeze` drops, acks follow on the next two cycles.
- Reset mid-operation: assert `rst`=0 in the cycle a grant is made. The next cycle shows `ack`=0, `change`=0, `shadow_count`=0, and the pointer is back at 0.

Source files
------------

// File: rtl/monitor_event_arbiter.sv
// Round-robin arbiter that serialises gateway join/leave events into single
// change/on_off pulses for the shared device monitor, refusing counter wraps.
module monitor_event_arbiter #(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] dir,
  input  logic               freeze,
  output logic [N_PORTS-1:0] ack,
  output logic               nack,
  output logic               change,
  output logic               on_off,
  output logic [CNT_W-1:0]   shadow_count,
  output logic               busy
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N_PORTS-1:0] ack_q, ack_d;
  logic               nack_q, nack_d;
  logic               change_q, change_d;
  logic               on_off_q, on_off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [N_PORTS-1:0] elig_s;
  logic               grant_vld_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [PTR_W:0]     sum_s;
  logic [PTR_W:0]     wrap_s;
  logic [PTR_W-1:0]   idx_s;
  logic               hit_s;
  logic               reject_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    return (g == PTR_W'(N_PORTS - 1)) ? {PTR_W{1'b0}} : g + PTR_W'(1);
  endfunction

  // The port acked this cycle is masked so a held req is not granted twice.
  assign elig_s = req & ~ack_q;

  // Round-robin search from the pointer upward with wrap-around.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {PTR_W{1'b0}};
    sum_s       = {(PTR_W+1){1'b0}};
    wrap_s      = {(PTR_W+1){1'b0}};
    idx_s       = {PTR_W{1'b0}};
    hit_s       = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum_s       = {1'b0, ptr_q} + (PTR_W+1)'(i);
      wrap_s      = (sum_s >= (PTR_W+1)'(N_PORTS)) ? sum_s - (PTR_W+1)'(N_PORTS) : sum_s;
      idx_s       = wrap_s[PTR_W-1:0];
      hit_s       = elig_s[idx_s] & ~grant_vld_s & ~freeze;
      grant_idx_s = hit_s ? idx_s : grant_idx_s;
      grant_vld_s = grant_vld_s | hit_s;
    end
  end

  // Grant evaluation: saturation check, pulse generation and shadow update.
  always_comb begin
    ack_d    = {N_PORTS{1'b0}};
    nack_d   = 1'b0;
    change_d = 1'b0;
    on_off_d = on_off_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    reject_s = 1'b0;
    busy_d   = |elig_s;
    if (grant_vld_s) begin
      ack_d[grant_idx_s] = 1'b1;
      ptr_d    = next_ptr(grant_idx_s);
      reject_s = dir[grant_idx_s] ? (cnt_q == CNT_MAX) : (cnt_q == {CNT_W{1'b0}});
      if (reject_s) begin
        nack_d = 1'b1;
      end else begin
        change_d = 1'b1;
        on_off_d = dir[grant_idx_s];
        cnt_d    = dir[grant_idx_s] ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q    <= {N_PORTS{1'b0}};
      nack_q   <= 1'b0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      ptr_q    <= {PTR_W{1'b0}};
    end else begin
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
    end
  end

  assign ack          = ack_q;
  assign nack         = nack_q;
  assign change       = change_q;
  assign on_off       = on_off_q;
  assign shadow_count = cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_monitor_event_arbiter.sv
// Directed-vector bench for monitor_event_arbiter with a model of the
// downstream monitor counter driven by change/on_off.
module tb_monitor_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] dir;
  logic       freeze;
  logic [3:0] ack;
  logic       nack;
  logic       change;
  logic       on_off;
  logic [7:0] shadow_count;
  logic       busy;
  logic [7:0] mon;

  int n_checks;
  int n_pass;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] dir;
    logic       frz;
    logic [3:0] ack;
    logic       nack;
    logic       chg;
    logic       onf;
    logic [7:0] cnt;
    logic [7:0] mon;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  monitor_event_arbiter #(.N_PORTS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .freeze(freeze),
    .ack(ack), .nack(nack), .change(change), .on_off(on_off),
    .shadow_count(shadow_count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor counter as it would sit behind the arbiter.
  always @(posedge clk) begin
    if (!rst) mon <= 8'd0;
    else if (change) mon <= on_off ? mon + 8'd1 : mon - 8'd1;
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] d, input logic f,
                     input logic [3:0] a, input logic nk, input logic c, input logic o,
                     input logic [7:0] cnt, input logic [7:0] m, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.dir = d; v.frz = f; v.ack = a; v.nack = nk;
    v.chg = c; v.onf = o; v.cnt = cnt; v.mon = m; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0; req = 4'b0000; dir = 4'b0000; freeze = 1'b0;

    //   rst  req      dir      frz   ack      nk    chg   onf   cnt     mon     busy
    add(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0);
    add(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0);
    add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 8'd1,   8'd0,   1'b1);
    add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 8'd2,   8'd1,   1'b1);
    add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 8'd3,   8'd2,   1'b1);
    add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 8'd4,   8'd3,   1'b1);
    add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 8'd5,   8'd4,   1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd5,   8'd5,   1'b0);
    add(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0);
    // single port 2 increment
    add(1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 8'd1,   8'd0,   1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0);
    // decrement to zero, then underflow refused
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd0,   8'd1,   1'b1);
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0);
    add(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0);
    // freeze holds two requests for five cycles
    for (int i = 0; i < 5; i++)
      add(1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    add(1'b1, 4'b0011, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 8'd1,   8'd0,   1'b1);
    add(1'b1, 4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 8'd2,   8'd1,   1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd2,   8'd2,   1'b0);
    // reset in a grant cycle; pointer must restart at port 0
    add(1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0);
    add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 8'd1,   8'd0,   1'b1);
    add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; dir = vecs[i].dir; freeze = vecs[i].frz;
      cycle();
      check("ack",          i, 32'(ack),          32'(vecs[i].ack));
      check("nack",         i, 32'(nack),         32'(vecs[i].nack));
      check("change",       i, 32'(change),       32'(vecs[i].chg));
      check("on_off",       i, 32'(on_off),       32'(vecs[i].onf));
      check("shadow_count", i, 32'(shadow_count), 32'(vecs[i].cnt));
      check("monitor",      i, 32'(mon),          32'(vecs[i].mon));
      check("busy",         i, 32'(busy),         32'(vecs[i].busy));
    end

    // Saturation: 255 increments with all ports requesting, then one refused.
    rst = 1'b0; req = 4'b0000; dir = 4'b0000; freeze = 1'b0;
    cycle();
    rst = 1'b1; req = 4'b1111; dir = 4'b1111;
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      cycle();
      if (change) pulses++;
    end
    check("sat_count",  1000, 32'(shadow_count), 32'd255);
    check("sat_pulses", 1000, 32'(pulses),       32'd255);
    cycle();
    check("sat_ack",    1001, 32'(ack),          32'h8);
    check("sat_nack",   1001, 32'(nack),         32'd1);
    check("sat_change", 1001, 32'(change),       32'd0);
    check("sat_hold",   1001, 32'(shadow_count), 32'd255);
    req = 4'b0001; dir = 4'b0000;
    cycle();
    check("dec_ack",    1002, 32'(ack),          32'h1);
    check("dec_nack",   1002, 32'(nack),         32'd0);
    check("dec_change", 1002, 32'(change),       32'd1);
    check("dec_on_off", 1002, 32'(on_off),       32'd0);
    check("dec_count",  1002, 32'(shadow_count), 32'd254);
    req = 4'b0000;
    cycle();
    check("dec_monitor", 1003, 32'(mon),    32'd254);
    check("dec_idle",    1003, 32'(change), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
